// File: rtl/hdr_reader_arbiter.sv
// Round-robin arbiter that shares one bitstream reader among header decoders.
// It sequences u(n)/ue(v) reads per granted session and has a timeout watchdog.
module hdr_reader_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024,
    parameter int SELW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   op_valid,
    input  logic [NREQ-1:0]   op_cmd,
    input  logic [5*NREQ-1:0] op_n,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   op_ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_value,
    output logic              rsp_error,
    output logic              br_start,
    output logic              br_cmd,
    output logic [4:0]        br_n,
    output logic [SELW-1:0]   br_sel,
    input  logic [31:0]       br_value,
    input  logic              br_done,
    input  logic              br_busy,
    input  logic              br_error,
    output logic [7:0]        timeout_cnt,
    output logic              arb_busy
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANTED = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;

    logic [1:0]      state;
    logic [SELW-1:0] last_grant;
    logic [TW-1:0]   timer;

    logic            scan_found;
    logic [SELW-1:0] scan_idx;
    int              scan_best;
    int              scan_dist;

    // The winner is the active requester at the smallest distance past last_grant.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_best  = NREQ;
        scan_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_dist = (i + NREQ - 1 - int'(last_grant)) % NREQ;
            if (req[i] && scan_dist < scan_best) begin
                scan_best  = scan_dist;
                scan_idx   = SELW'(i);
                scan_found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_grant  <= SELW'(NREQ - 1);
            timer       <= '0;
            grant       <= '0;
            op_ack      <= '0;
            rsp_valid   <= '0;
            rsp_value   <= '0;
            rsp_error   <= 1'b0;
            br_start    <= 1'b0;
            br_cmd      <= 1'b0;
            br_n        <= '0;
            br_sel      <= '0;
            timeout_cnt <= '0;
            arb_busy    <= 1'b0;
        end else begin
            op_ack    <= '0;
            rsp_valid <= '0;
            br_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scan_found) begin
                        grant    <= NREQ'(1) << scan_idx;
                        br_sel   <= scan_idx;
                        arb_busy <= 1'b1;
                        state    <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    if (!req[br_sel]) begin
                        grant      <= '0;
                        arb_busy   <= 1'b0;
                        last_grant <= br_sel;
                        state      <= S_IDLE;
                    end else if (op_valid[br_sel] && !br_busy) begin
                        br_start <= 1'b1;
                        op_ack   <= NREQ'(1) << br_sel;
                        br_cmd   <= op_cmd[br_sel];
                        br_n     <= op_n[int'(br_sel)*5 +: 5];
                        timer    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A done in the expiry cycle still counts as a normal response.
                    if (br_done) begin
                        rsp_valid <= NREQ'(1) << br_sel;
                        rsp_value <= br_value;
                        rsp_error <= br_error;
                        state     <= S_GRANTED;
                    end else if (timer == TIMER_LAST) begin
                        rsp_valid <= NREQ'(1) << br_sel;
                        rsp_value <= '0;
                        rsp_error <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        state <= S_GRANTED;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdr_reader_arbiter.sv
// Self-checking bench for hdr_reader_arbiter: directed scenarios plus randomized
// sessions compared against a round-robin / reader reference model.
module tb_hdr_reader_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;
    localparam int SELW    = 2;
    localparam int OUTW    = 3*NREQ + SELW + 49;

    typedef struct packed {
        logic            acked;
        logic [7:0]      wait_cycles;
        logic [NREQ-1:0] ack;
        logic            start;
        logic            cmd;
        logic [4:0]      n;
        logic [SELW-1:0] sel;
        logic [NREQ-1:0] rv;
        logic [31:0]     val;
        logic            err;
    } op_obs_t;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   op_valid;
    logic [NREQ-1:0]   op_cmd;
    logic [5*NREQ-1:0] op_n;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   op_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_value;
    logic              rsp_error;
    logic              br_start;
    logic              br_cmd;
    logic [4:0]        br_n;
    logic [SELW-1:0]   br_sel;
    logic [31:0]       br_value;
    logic              br_done;
    logic              br_busy;
    logic              br_error;
    logic [7:0]        timeout_cnt;
    logic              arb_busy;
    logic [OUTW-1:0]   all_out;

    int checks;
    int errors;
    int model_last;
    int model_tcnt;

    hdr_reader_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .SELW(SELW)) dut (
        .clk(clk), .reset(reset), .req(req), .op_valid(op_valid), .op_cmd(op_cmd),
        .op_n(op_n), .grant(grant), .op_ack(op_ack), .rsp_valid(rsp_valid),
        .rsp_value(rsp_value), .rsp_error(rsp_error), .br_start(br_start),
        .br_cmd(br_cmd), .br_n(br_n), .br_sel(br_sel), .br_value(br_value),
        .br_done(br_done), .br_busy(br_busy), .br_error(br_error),
        .timeout_cnt(timeout_cnt), .arb_busy(arb_busy)
    );

    assign all_out = {grant, op_ack, rsp_valid, rsp_value, rsp_error, br_start,
                      br_cmd, br_n, br_sel, timeout_cnt, arb_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_watchdog: got time %0t required finish earlier", $time);
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first active requester strictly after the last grant.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic op_obs_t exp_op(input int g, input logic cmd, input logic [4:0] n,
                                       input logic [31:0] val, input logic err, input int pre);
        op_obs_t e;
        e.acked       = 1'b1;
        e.wait_cycles = 8'(pre + 1);
        e.ack         = onehot(g);
        e.start       = 1'b1;
        e.cmd         = cmd;
        e.n           = n;
        e.sel         = SELW'(g);
        e.rv          = onehot(g);
        e.val         = val;
        e.err         = err;
        return e;
    endfunction

    // Issues one read for requester i; the reader stays busy 'pre' cycles before
    // accepting, then answers 'lat' cycles after start. Returns what was observed.
    task automatic do_op(input int i, input logic cmd, input logic [4:0] n,
                         input logic [31:0] val, input logic err,
                         input int pre, input int lat, output op_obs_t o);
        o = '0;
        op_valid[i]       = 1'b1;
        op_cmd[i]         = cmd;
        op_n[5*i +: 5]    = n;
        br_busy           = (pre > 0);
        for (int c = 1; c <= 60 && !o.acked; c++) begin
            tick();
            if (op_ack != '0) begin
                o.acked       = 1'b1;
                o.wait_cycles = 8'(c);
                o.ack         = op_ack;
                o.start       = br_start;
                o.cmd         = br_cmd;
                o.n           = br_n;
                o.sel         = br_sel;
            end else if (c >= pre) begin
                br_busy = 1'b0;
            end
        end
        op_valid[i] = 1'b0;
        if (!o.acked) begin
            br_busy = 1'b0;
            return;
        end
        br_busy = 1'b1;
        repeat (lat) tick();
        br_done  = 1'b1;
        br_value = val;
        br_error = err;
        tick();
        br_done  = 1'b0;
        br_busy  = 1'b0;
        br_error = 1'b0;
        o.rv  = rsp_valid;
        o.val = rsp_value;
        o.err = rsp_error;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '1;
        op_valid = '1;
        tick();
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        reset = 1'b1;
        req = '0;
        op_valid = '0;
        tick();
        checks++;
        if ({grant, arb_busy} !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got grant=%b busy=%b required 0", grant, arb_busy);
        end
    endtask

    task automatic test_contention();
        int g;
        op_obs_t o;
        logic cmd;
        logic [4:0] n;
        logic [31:0] v;
        req = '1;
        for (int s = 0; s < 4; s++) begin
            g = rr_pick(model_last, req);
            tick();
            checks++;
            if ({grant, arb_busy} !== {onehot(g), 1'b1}) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b required %b", s, grant, onehot(g));
            end
            cmd = 1'($urandom_range(0, 1));
            n = 5'($urandom_range(1, 31));
            v = $urandom;
            do_op(g, cmd, n, v, 1'b0, 0, $urandom_range(0, 3), o);
            checks++;
            if (o !== exp_op(g, cmd, n, v, 1'b0, 0)) begin
                errors++;
                $display("FAIL contention_op%0d: got %h required %h", s, o, exp_op(g, cmd, n, v, 1'b0, 0));
            end
            req[g] = 1'b0;
            tick();
            model_last = g;
            checks++;
            if (grant !== '0) begin
                errors++;
                $display("FAIL contention_gap%0d: got %b required 000", s, grant);
            end
            if (s < 3) req[g] = 1'b1;
            else req = '0;
        end
    endtask

    task automatic test_single_sps();
        int g;
        op_obs_t o;
        req = 3'b001;
        g = rr_pick(model_last, req);
        tick();
        checks++;
        if ({grant, arb_busy} !== {3'b001, 1'b1}) begin
            errors++;
            $display("FAIL sps_grant: got %b required 001", grant);
        end
        do_op(g, 1'b0, 5'd8, 32'h64, 1'b0, 0, 2, o);
        checks++;
        if (o !== exp_op(0, 1'b0, 5'd8, 32'h64, 1'b0, 0)) begin
            errors++;
            $display("FAIL sps_op: got %h required %h", o, exp_op(0, 1'b0, 5'd8, 32'h64, 1'b0, 0));
        end
        req = '0;
        tick();
        model_last = g;
        checks++;
        if ({grant, arb_busy} !== '0) begin
            errors++;
            $display("FAIL sps_release: got %b required 000", grant);
        end
    endtask

    task automatic test_timeout();
        int g;
        int k;
        logic acked;
        op_obs_t o;
        logic [31:0] v;
        req = 3'b001;
        g = rr_pick(model_last, req);
        tick();
        op_valid[g] = 1'b1;
        op_cmd[g] = 1'b0;
        op_n[5*g +: 5] = 5'd12;
        acked = 1'b0;
        for (int c = 0; c < 10 && !acked; c++) begin
            tick();
            if (op_ack != '0) acked = 1'b1;
        end
        op_valid[g] = 1'b0;
        br_busy = 1'b1;
        checks++;
        if (acked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ack: got no op_ack required op_ack");
        end
        k = 0;
        for (int c = 1; c <= 40 && k == 0; c++) begin
            tick();
            if (rsp_valid != '0) k = c;
        end
        model_tcnt++;
        checks++;
        if (k != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", k, TIMEOUT);
        end
        checks++;
        if ({rsp_valid, rsp_value, rsp_error} !== {onehot(g), 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_rsp: got v=%b val=%h err=%b required v=%b val=0 err=1",
                     rsp_valid, rsp_value, rsp_error, onehot(g));
        end
        checks++;
        if (timeout_cnt !== 8'(model_tcnt)) begin
            errors++;
            $display("FAIL timeout_cnt: got %0d required %0d", timeout_cnt, model_tcnt);
        end
        br_done = 1'b1;
        br_value = $urandom;
        tick();
        br_done = 1'b0;
        br_busy = 1'b0;
        checks++;
        if ({rsp_valid, timeout_cnt} !== {3'b000, 8'(model_tcnt)}) begin
            errors++;
            $display("FAIL late_done_ignored: got v=%b cnt=%0d required v=000 cnt=%0d",
                     rsp_valid, timeout_cnt, model_tcnt);
        end
        v = $urandom;
        do_op(g, 1'b1, 5'd3, v, 1'b0, 1, 4, o);
        checks++;
        if (o !== exp_op(g, 1'b1, 5'd3, v, 1'b0, 1)) begin
            errors++;
            $display("FAIL after_timeout_op: got %h required %h", o, exp_op(g, 1'b1, 5'd3, v, 1'b0, 1));
        end
        req = '0;
        tick();
        model_last = g;
    endtask

    task automatic test_error_forward();
        int g;
        op_obs_t o;
        logic [4:0] n;
        logic [31:0] v;
        req = 3'b100;
        g = rr_pick(model_last, req);
        tick();
        n = 5'($urandom_range(1, 31));
        v = $urandom;
        do_op(g, 1'b1, n, v, 1'b1, 0, $urandom_range(0, 5), o);
        checks++;
        if (o !== exp_op(g, 1'b1, n, v, 1'b1, 0)) begin
            errors++;
            $display("FAIL error_forward: got %h required %h", o, exp_op(g, 1'b1, n, v, 1'b1, 0));
        end
        tick();
        checks++;
        if ({grant, rsp_valid} !== {onehot(g), 3'b000}) begin
            errors++;
            $display("FAIL error_grant_kept: got %b required %b", grant, onehot(g));
        end
        req = '0;
        tick();
        model_last = g;
    endtask

    task automatic test_drop_mid_op();
        int g;
        logic acked;
        logic stray;
        logic [31:0] v;
        req = 3'b010;
        g = rr_pick(model_last, req);
        tick();
        op_valid[g] = 1'b1;
        op_cmd[g] = 1'b1;
        acked = 1'b0;
        for (int c = 0; c < 10 && !acked; c++) begin
            tick();
            if (op_ack != '0) acked = 1'b1;
        end
        op_valid[g] = 1'b0;
        br_busy = 1'b1;
        req = 3'b100;
        op_valid[2] = 1'b1;
        op_cmd[2] = 1'b0;
        op_n[14:10] = 5'd20;
        stray = !acked;
        repeat (3) begin
            tick();
            if (op_ack != '0 || grant !== onehot(g)) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL drop_hold: got ack=%b grant=%b required ack=000 grant=%b", op_ack, grant, onehot(g));
        end
        v = $urandom;
        br_done = 1'b1;
        br_value = v;
        tick();
        br_done = 1'b0;
        br_busy = 1'b0;
        checks++;
        if ({rsp_valid, rsp_value, rsp_error} !== {onehot(g), v, 1'b0}) begin
            errors++;
            $display("FAIL drop_rsp: got v=%b val=%h err=%b required v=%b val=%h err=0",
                     rsp_valid, rsp_value, rsp_error, onehot(g), v);
        end
        tick();
        model_last = g;
        checks++;
        if ({grant, op_ack} !== '0) begin
            errors++;
            $display("FAIL drop_release: got grant=%b ack=%b required 000/000", grant, op_ack);
        end
        g = rr_pick(model_last, req);
        tick();
        checks++;
        if ({grant, op_ack} !== {onehot(g), 3'b000}) begin
            errors++;
            $display("FAIL drop_next_grant: got grant=%b ack=%b required %b/000", grant, op_ack, onehot(g));
        end
        tick();
        checks++;
        if ({op_ack, br_start, br_sel, br_cmd, br_n} !== {3'b100, 1'b1, 2'd2, 1'b0, 5'd20}) begin
            errors++;
            $display("FAIL drop_pending_issue: got ack=%b start=%b sel=%0d cmd=%b n=%0d required 100/1/2/0/20",
                     op_ack, br_start, br_sel, br_cmd, br_n);
        end
        op_valid[2] = 1'b0;
        br_busy = 1'b1;
        br_done = 1'b1;
        br_value = 32'hCAFE_0002;
        tick();
        br_done = 1'b0;
        br_busy = 1'b0;
        req = '0;
        tick();
        model_last = g;
    endtask

    task automatic test_reset_mid_op();
        int g;
        req = 3'b001;
        g = rr_pick(model_last, req);
        tick();
        op_valid[g] = 1'b1;
        tick();
        op_valid[g] = 1'b0;
        br_busy = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: got %h required 0", all_out);
        end
        reset = 1'b1;
        br_busy = 1'b0;
        req = 3'b110;
        model_last = NREQ - 1;
        model_tcnt = 0;
        g = rr_pick(model_last, req);
        tick();
        checks++;
        if (grant !== onehot(g)) begin
            errors++;
            $display("FAIL reset_first_grant: got %b required %b", grant, onehot(g));
        end
        req = '0;
        tick();
        model_last = g;
    endtask

    task automatic test_random_sessions();
        int g;
        int nops;
        int pre;
        op_obs_t o;
        logic [NREQ-1:0] pattern;
        logic cmd;
        logic err;
        logic [4:0] n;
        logic [31:0] v;
        for (int s = 0; s < 30; s++) begin
            pattern = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = pattern;
            g = rr_pick(model_last, pattern);
            tick();
            checks++;
            if ({grant, arb_busy, br_sel} !== {onehot(g), 1'b1, SELW'(g)}) begin
                errors++;
                $display("FAIL rand_grant%0d: got grant=%b sel=%0d required %b/%0d", s, grant, br_sel, onehot(g), g);
            end
            nops = $urandom_range(1, 3);
            for (int k = 0; k < nops; k++) begin
                cmd = 1'($urandom_range(0, 1));
                err = ($urandom_range(0, 3) == 0);
                n = 5'($urandom_range(0, 31));
                v = $urandom;
                pre = $urandom_range(0, 2);
                do_op(g, cmd, n, v, err, pre, $urandom_range(0, 6), o);
                checks++;
                if (o !== exp_op(g, cmd, n, v, err, pre)) begin
                    errors++;
                    $display("FAIL rand_op%0d_%0d: got %h required %h", s, k, o, exp_op(g, cmd, n, v, err, pre));
                end
            end
            req[g] = 1'b0;
            tick();
            model_last = g;
            checks++;
            if ({grant, arb_busy} !== '0) begin
                errors++;
                $display("FAIL rand_release%0d: got %b required 000", s, grant);
            end
            req = '0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_last = NREQ - 1;
        model_tcnt = 0;
        reset = 1'b0;
        req = '0;
        op_valid = '0;
        op_cmd = '0;
        op_n = '0;
        br_value = '0;
        br_done = 1'b0;
        br_busy = 1'b0;
        br_error = 1'b0;
        test_reset();
        test_contention();
        test_single_sps();
        test_timeout();
        test_error_forward();
        test_drop_mid_op();
        test_reset_mid_op();
        test_random_sessions();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdr_reader_arbiter.md
# hdr_reader_arbiter

Round-robin arbiter and sequencer that shares one bitstream reader among NREQ header decoders (SPS, PPS, slice header).
- A requester holds a grant for a whole parse session and issues read operations one at a time: fixed-width u(n) or exp-Golomb ue(v).
- The block drives the reader's start/cmd/n handshake and steers the bitstream-select mux, so the reader's bit position belongs to one decoder per session.
- It routes each result back to the granted decoder.
- A watchdog converts a hung read into an error response.

## Interface
- NREQ, 3, number of requesters (2..8); index 0 = SPS, 1 = PPS, 2 = slice header.
- TIMEOUT, 1024, max cycles from br_start to br_done before a timeout response.
- SELW, 2, width of br_sel; must satisfy 2^SELW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- req  in  NREQ  per-requester session request; held high for the whole session.
- op_valid  in  NREQ  per-requester read-operation request; held until op_ack.
- op_cmd  in  NREQ  per-requester command: 0 = u(n), 1 = ue(v).
- op_n  in  5*NREQ  per-requester bit count for u(n); slice [5i+4:5i] belongs to requester i.
- grant  out  NREQ  one-hot session grant.
- op_ack  out  NREQ  one-cycle pulse: operation accepted.
- rsp_valid  out  NREQ  one-cycle pulse: response available to requester i.
- rsp_value  out  32  read value, valid with rsp_valid.
- rsp_error  out  1  reader error or timeout, valid with rsp_valid.
- br_start  out  1  one-cycle start pulse to the reader.
- br_cmd  out  1  command to the reader; held from br_start until the next op.
- br_n  out  5  bit count to the reader; held from br_start until the next op.
- br_sel  out  SELW  bitstream-select index = granted requester.
- br_value  in  32  reader result.
- br_done  in  1  reader done pulse.
- br_busy  in  1  reader busy.
- br_error  in  1  reader error, valid with br_done.
- timeout_cnt  out  8  saturating count of timeouts.
- arb_busy  out  1  high when any grant is active.

## Operation
- States: S_IDLE, S_GRANTED, S_WAIT.
- S_IDLE:
  - If any req is high, grant the first requester at or after (last_grant+1) mod NREQ, scanning upward.
  - Set grant[g], br_sel=g, go to S_GRANTED. last_grant resets to NREQ-1, so requester 0 wins first.
- S_GRANTED, checked in priority order:
  1. If req[g]==0: clear grant, set last_grant=g, go to S_IDLE.
  2. Else if op_valid[g]==1 and br_busy==0: pulse br_start and op_ack[g]; latch br_cmd=op_cmd[g] and br_n=op_n[g]; clear the timer; go to S_WAIT.
  3. Otherwise wait. op_valid from non-granted requesters is ignored (never acked).
- S_WAIT:
  - On br_done: pulse rsp_valid[g], rsp_value=br_value, rsp_error=br_error; go to S_GRANTED.
  - Else if the timer reaches TIMEOUT-1: pulse rsp_valid[g] with rsp_value=0 and rsp_error=1; increment timeout_cnt (saturates at 255); go to S_GRANTED.
  - A late br_done after a timeout is ignored. The next op waits for br_busy==0.
- req[g] dropping during S_WAIT does not abort: the response is still delivered, then release happens in S_GRANTED.
- Timer width is clog2(TIMEOUT); the timer does not wrap within an operation.
- Reset (any state, including mid-operation): state=S_IDLE, last_grant=NREQ-1. All outputs 0: grant, op_ack, rsp_valid, rsp_value, rsp_error, br_start, br_cmd, br_n, br_sel, timeout_cnt, arb_busy. The reader is reset by the same signal.

## Timing
- All outputs are registered.
- Grant: asserted 1 cycle after req is sampled in S_IDLE.
- Operation issue: br_start/op_ack asserted 1 cycle after op_valid&&!br_busy is sampled in S_GRANTED. Earliest is the cycle after grant rises.
- Response: rsp_valid asserted 1 cycle after br_done is sampled.
- Release: grant falls 1 cycle after req low is sampled. The next grant is 1 cycle later, so the gap between grants is at least 1 cycle with grant==0.
- Back-to-back ops: the next br_start comes no earlier than 1 cycle after rsp_valid.
- Fairness: a requester with req held waits at most NREQ-1 sessions.
- Simultaneous br_done and timer expiry: br_done wins (normal response, no timeout count).

## Test plan
- Single SPS session: req[0]=1, then u(8) op with reader returning 0x64.
  - Required: grant=001 next cycle; br_start with cmd=0, n=8, br_sel=0; rsp_valid[0] with rsp_value=0x64, rsp_error=0.
  - Then drop req → grant=000.
- Contention: req=111 held, each session does one op and releases.
  - Required: grant order 001, 010, 100, 001, with a 1-cycle idle gap between grants.
- Timeout: TIMEOUT=16, reader never asserts done.
  - Required: rsp_valid with rsp_error=1 and rsp_value=0 exactly 16 cycles after br_start; timeout_cnt=1; a late br_done is ignored.
- Error forwarding: ue(v) op with br_error=1 at done.
  - Required: rsp_error=1, grant kept while req is held.
- Drop mid-op: req[1] falls during S_WAIT.
  - Required: the response is still delivered to requester 1, then grant clears; op_valid[2] raised meanwhile is not acked until requester 2 is granted.
- Reset mid-op: assert reset during S_WAIT.
  - Required: all outputs 0 next edge; after release, req=110 grants requester 1 first (scan from last_grant+1 = 0, req[0] low).
